apple_iie_video_scanner: RTL and testbench

- Video timing scanner, directly downstream of the Apple IIe timing PAL. Consumes the PAL's phi_0 clock phase as a sampled level and generates the horizontal/vertical scan counters of the original IOU.
- Produces blanking, sync, frame-start and text/hires memory offsets for the video fetch and the video encoder.
- Runs entirely in the clk_14M domain. phi_0 is an enable source, not a clock.

---
 rtl/apple_iie_video_pkg.sv | 39 +++
 rtl/apple_iie_video_scanner_scan_addr.sv | 34 +++
 rtl/apple_iie_video_scanner.sv | 114 +++++++++++
 tb/tb_apple_iie_video_scanner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/apple_iie_video_pkg.sv
// rtl/apple_iie_video_pkg.sv - Apple IIe video scan constants and decode helper
package apple_iie_video_pkg;

   // Horizontal counter landmarks (7-bit IOU counter)
   localparam logic [6:0] H_LINE_START = 7'h00;
   localparam logic [6:0] H_FIRST      = 7'h40;
   localparam logic [6:0] H_LAST       = 7'h7F;
   localparam logic [6:0] H_ACTIVE     = 7'h58;
   localparam logic [6:0] HSYNC_BEG    = 7'h49;
   localparam logic [6:0] HSYNC_END    = 7'h4C;

   // Vertical counter landmarks (9-bit IOU counter)
   localparam logic [8:0] V_LAST       = 9'h1FF;
   localparam logic [8:0] V_ACTIVE     = 9'h100;
   localparam logic [8:0] V_ACTIVE_END = 9'h1C0;
   localparam logic [8:0] VSYNC_BEG    = 9'h1E0;
   localparam logic [8:0] VSYNC_END    = 9'h1E3;
   localparam logic [8:0] V_FIRST_NTSC = 9'h0FA;
   localparam logic [8:0] V_FIRST_PAL  = 9'h0C8;

   // Blank/sync levels derived from a counter pair
   typedef struct packed {
      logic hbl;
      logic vbl;
      logic hsync;
      logic vsync;
   } scan_decode_t;

   // Blank and sync decode for a given counter pair
   function automatic scan_decode_t scan_decode(input logic [6:0] h, input logic [8:0] v);
      scan_decode_t d;
      d.hbl   = (h < H_ACTIVE);
      d.vbl   = (v < V_ACTIVE) || (v >= V_ACTIVE_END);
      d.hsync = (h >= HSYNC_BEG) && (h <= HSYNC_END);
      d.vsync = (v >= VSYNC_BEG) && (v <= VSYNC_END);
      return d;
   endfunction

endpackage

// File: rtl/apple_iie_video_scanner_scan_addr.sv
// rtl/apple_iie_video_scanner_scan_addr.sv - maps scan counters to text and hires offsets
module apple_iie_scan_addr
   import apple_iie_video_pkg::*;
(
   input  logic [6:0]  i_h_count,
   input  logic [8:0]  i_v_count,
   output logic [9:0]  o_text_offset,
   output logic [12:0] o_hires_offset
);

   logic        w_active;
   logic [7:0]  w_y;
   logic [6:0]  w_col;
   logic [4:0]  w_row;
   logic [2:0]  w_rb;
   logic [9:0]  w_text;
   logic [12:0] w_hires;

   // Interleaved Apple II memory map: 8 row groups of 0x80, thirds of 0x28
   always_comb begin
      w_active = (i_h_count >= H_ACTIVE) && (i_v_count >= V_ACTIVE) &&
                 (i_v_count < V_ACTIVE_END);
      // Inside the active region v - 0x100 is just the low byte of v
      w_y      = i_v_count[7:0];
      w_col    = i_h_count - H_ACTIVE;
      w_row    = w_y[7:3];
      w_rb     = w_y[2:0];
      w_text   = {w_row[2:0], 7'd0} + (10'(w_row[4:3]) * 10'd40) + 10'(w_col);
      w_hires  = {w_rb, 10'd0} + {3'd0, w_text};
      o_text_offset  = w_active ? w_text  : 10'd0;
      o_hires_offset = w_active ? w_hires : 13'd0;
   end

endmodule

// File: rtl/apple_iie_video_scanner.sv
// rtl/apple_iie_video_scanner.sv - IOU horizontal/vertical scan counters and video decodes
module apple_iie_video_scanner
   import apple_iie_video_pkg::*;
#(
   parameter int PAL_MODE = 0
)
(
   input  logic        clk_14M,
   input  logic        reset,
   input  logic        clk_phi_0,
   output logic        phi0_tick,
   output logic [6:0]  h_count,
   output logic [8:0]  v_count,
   output logic        hbl,
   output logic        vbl,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic [9:0]  text_offset,
   output logic [12:0] hires_offset
);

   localparam logic [8:0] V_FIRST = (PAL_MODE != 0) ? V_FIRST_PAL : V_FIRST_NTSC;

   logic        r_phi0_q;
   logic        r_phi0_tick;
   logic        r_frame_start;
   logic [6:0]  r_h_count;
   logic [8:0]  r_v_count;
   logic        r_hbl;
   logic        r_vbl;
   logic        r_hsync;
   logic        r_vsync;
   logic [9:0]  r_text_offset;
   logic [12:0] r_hires_offset;

   logic         w_fall;
   logic         w_line_end;
   logic         w_frame_wrap;
   logic [6:0]   w_h_next;
   logic [8:0]   w_v_next;
   scan_decode_t w_decode;
   logic [9:0]   w_text_next;
   logic [12:0]  w_hires_next;

   // Next counter state: H skips the undefined 0x01-0x3F range, V wraps to V_FIRST
   always_comb begin
      w_fall       = r_phi0_q & ~clk_phi_0;
      w_line_end   = (r_h_count == H_LAST);
      w_frame_wrap = w_line_end && (r_v_count == V_LAST);
      w_h_next     = r_h_count + 7'd1;
      w_v_next     = r_v_count;
      if (r_h_count == H_LINE_START) begin
         w_h_next = H_FIRST;
      end else if (w_line_end) begin
         w_h_next = H_LINE_START;
      end
      if (w_line_end) begin
         w_v_next = w_frame_wrap ? V_FIRST : (r_v_count + 9'd1);
      end
      w_decode = scan_decode(w_h_next, w_v_next);
   end

   // Offsets are decoded from the next counters so they land with them
   apple_iie_scan_addr u_scan_addr (
      .i_h_count      (w_h_next),
      .i_v_count      (w_v_next),
      .o_text_offset  (w_text_next),
      .o_hires_offset (w_hires_next)
   );

   // Counters and decodes advance together on each sampled phi_0 fall
   always_ff @(posedge clk_14M) begin
      if (reset) begin
         r_phi0_q       <= 1'b0;
         r_phi0_tick    <= 1'b0;
         r_frame_start  <= 1'b0;
         r_h_count      <= H_LINE_START;
         r_v_count      <= V_FIRST;
         r_hbl          <= 1'b1;
         r_vbl          <= 1'b1;
         r_hsync        <= 1'b0;
         r_vsync        <= 1'b0;
         r_text_offset  <= 10'd0;
         r_hires_offset <= 13'd0;
      end else begin
         r_phi0_q      <= clk_phi_0;
         r_phi0_tick   <= w_fall;
         r_frame_start <= w_fall & w_frame_wrap;
         if (w_fall) begin
            r_h_count      <= w_h_next;
            r_v_count      <= w_v_next;
            r_hbl          <= w_decode.hbl;
            r_vbl          <= w_decode.vbl;
            r_hsync        <= w_decode.hsync;
            r_vsync        <= w_decode.vsync;
            r_text_offset  <= w_text_next;
            r_hires_offset <= w_hires_next;
         end
      end
   end

   assign phi0_tick    = r_phi0_tick;
   assign frame_start  = r_frame_start;
   assign h_count      = r_h_count;
   assign v_count      = r_v_count;
   assign hbl          = r_hbl;
   assign vbl          = r_vbl;
   assign hsync        = r_hsync;
   assign vsync        = r_vsync;
   assign text_offset  = r_text_offset;
   assign hires_offset = r_hires_offset;

endmodule

// File: tb/tb_apple_iie_video_scanner.sv
// tb/tb_apple_iie_video_scanner.sv - self-checking bench for apple_iie_video_scanner
module tb_apple_iie_video_scanner;

   logic clk_14M = 1'b0;
   logic reset;
   logic clk_phi_0;

   logic        n_tick, n_fs, n_hbl, n_vbl, n_hs, n_vs;
   logic [6:0]  n_h;
   logic [8:0]  n_v;
   logic [9:0]  n_txt;
   logic [12:0] n_hr;
   logic        p_tick, p_fs, p_hbl, p_vbl, p_hs, p_vs;
   logic [6:0]  p_h;
   logic [8:0]  p_v;
   logic [9:0]  p_txt;
   logic [12:0] p_hr;

   int total = 0;
   int bad   = 0;

   // Reference model: position within line (0..64) and line index within frame
   int  m_pos [2];
   int  m_line[2];
   int  n_lines[2] = '{262, 312};
   int  v_first[2] = '{250, 200};
   bit  exp_tick;
   bit  exp_fs[2];
   bit  prev_phi = 1'b0;
   int  falls_since_reset = 0;
   int  pal_fs_seen = 0;

   always #5 clk_14M = ~clk_14M;

   apple_iie_video_scanner #(.PAL_MODE(0)) u_ntsc (
      .clk_14M(clk_14M), .reset(reset), .clk_phi_0(clk_phi_0),
      .phi0_tick(n_tick), .h_count(n_h), .v_count(n_v),
      .hbl(n_hbl), .vbl(n_vbl), .hsync(n_hs), .vsync(n_vs),
      .frame_start(n_fs), .text_offset(n_txt), .hires_offset(n_hr)
   );

   apple_iie_video_scanner #(.PAL_MODE(1)) u_pal (
      .clk_14M(clk_14M), .reset(reset), .clk_phi_0(clk_phi_0),
      .phi0_tick(p_tick), .h_count(p_h), .v_count(p_v),
      .hbl(p_hbl), .vbl(p_vbl), .hsync(p_hs), .vsync(p_vs),
      .frame_start(p_fs), .text_offset(p_txt), .hires_offset(p_hr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int mh(input int pos);
      return (pos == 0) ? 0 : 63 + pos;
   endfunction

   function automatic int mv(input int idx);
      return v_first[idx] + m_line[idx];
   endfunction

   function automatic bit in_active(input int h, input int v);
      return (h >= 88) && (v >= 256) && (v < 448);
   endfunction

   function automatic int exp_text(input int h, input int v);
      int y, row;
      if (!in_active(h, v)) return 0;
      y   = v - 256;
      row = y / 8;
      return (row % 8) * 128 + (row / 8) * 40 + (h - 88);
   endfunction

   function automatic int exp_hires(input int h, input int v);
      if (!in_active(h, v)) return 0;
      return ((v - 256) % 8) * 1024 + exp_text(h, v);
   endfunction

   task automatic check_dut(input string nm, input int idx, input logic tick, input logic fs,
                            input logic [6:0] h, input logic [8:0] v, input logic hb,
                            input logic vb, input logic hs, input logic vs,
                            input logic [9:0] txt, input logic [12:0] hr);
      int eh, ev;
      eh = mh(m_pos[idx]);
      ev = mv(idx);
      check_eq({nm, " tick"},  32'(tick), 32'(exp_tick));
      check_eq({nm, " frame"}, 32'(fs),   32'(exp_fs[idx]));
      check_eq({nm, " h"},     32'(h),    eh);
      check_eq({nm, " v"},     32'(v),    ev);
      check_eq({nm, " hbl"},   32'(hb),   32'(eh < 88));
      check_eq({nm, " vbl"},   32'(vb),   32'((ev < 256) || (ev >= 448)));
      check_eq({nm, " hsync"}, 32'(hs),   32'((eh >= 73) && (eh <= 76)));
      check_eq({nm, " vsync"}, 32'(vs),   32'((ev >= 480) && (ev <= 483)));
      check_eq({nm, " text"},  32'(txt),  exp_text(eh, ev));
      check_eq({nm, " hires"}, 32'(hr),   exp_hires(eh, ev));
   endtask

   // One clk_14M cycle: drive at negedge, model the posedge, compare at next negedge
   task automatic cyc(input logic phi, input logic rst);
      bit fall;
      int eh, ev;
      clk_phi_0 = phi;
      reset     = rst;
      @(posedge clk_14M);
      fall = prev_phi && !phi;
      exp_tick = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_fs[i] = 1'b0;
         if (rst) begin
            m_pos[i]  = 0;
            m_line[i] = 0;
         end else if (fall) begin
            m_pos[i] = (m_pos[i] + 1) % 65;
            if (m_pos[i] == 0) begin
               m_line[i] = (m_line[i] + 1) % n_lines[i];
               if (m_line[i] == 0) exp_fs[i] = 1'b1;
            end
         end
      end
      if (!rst) exp_tick = fall;
      prev_phi = rst ? 1'b0 : phi;
      if (rst) falls_since_reset = 0;
      else if (fall) falls_since_reset++;
      @(negedge clk_14M);
      check_dut("ntsc", 0, n_tick, n_fs, n_h, n_v, n_hbl, n_vbl, n_hs, n_vs, n_txt, n_hr);
      check_dut("pal",  1, p_tick, p_fs, p_h, p_v, p_hbl, p_vbl, p_hs, p_vs, p_txt, p_hr);
      if (p_fs) pal_fs_seen++;
      if (exp_tick) begin
         eh = mh(m_pos[0]);
         ev = mv(0);
         if (falls_since_reset == 1)  check_eq("first fall h", 32'(n_h), 32'h40);
         if (falls_since_reset == 65) begin
            check_eq("line65 h", 32'(n_h), 32'h00);
            check_eq("line65 v", 32'(n_v), 32'h0FB);
         end
         if (ev == 256 && eh == 88) begin
            check_eq("addr100 text",  32'(n_txt), 32'h000);
            check_eq("addr100 hires", 32'(n_hr),  32'h0000);
         end
         if (ev == 257 && eh == 88) check_eq("addr101 hires", 32'(n_hr), 32'h0400);
         if (ev == 320 && eh == 88) check_eq("addr140 text",  32'(n_txt), 32'h028);
         if (ev == 447 && eh == 127) begin
            check_eq("addr1bf text",  32'(n_txt), 32'h3F7);
            check_eq("addr1bf hires", 32'(n_hr),  32'h1FF7);
         end
         if (ev == 288 && eh == 87) begin
            check_eq("h57 text", 32'(n_txt), 32'h0);
            check_eq("h57 hbl",  32'(n_hbl), 32'h1);
         end
         if (exp_fs[0]) check_eq("ntsc wrap v", 32'(n_v), 32'h0FA);
         if (exp_fs[1]) check_eq("pal wrap v",  32'(p_v), 32'h0C8);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      clk_phi_0 = 1'b0;
      reset     = 1'b1;
      @(negedge clk_14M);
      repeat (3) cyc(1'b0, 1'b1);

      // Nominal phi_0: 14 clocks per period, 50% duty
      for (int f = 0; f < 130; f++) begin
         repeat (7) cyc(1'b1, 1'b0);
         repeat (7) cyc(1'b0, 1'b0);
      end

      // Stuck high, then stuck low: nothing may move
      repeat (100) cyc(1'b1, 1'b0);
      repeat (100) cyc(1'b0, 1'b0);

      // Randomized fast phi_0 through a full PAL frame (covers NTSC wrap too)
      for (int f = 0; f < 312 * 65 + 100; f++) begin
         repeat (1 + $urandom_range(0, 1)) cyc(1'b1, 1'b0);
         repeat (1 + $urandom_range(0, 1)) cyc(1'b0, 1'b0);
      end
      check_eq("pal frame seen", 32'(pal_fs_seen > 0), 32'h1);

      // Reset mid-line at h=0x63, with a coincident fall that must be ignored
      guard = 0;
      while (mh(m_pos[0]) != 99 && guard < 200) begin
         cyc(1'b1, 1'b0);
         cyc(1'b0, 1'b0);
         guard++;
      end
      check_eq("reach h63", 32'(n_h), 32'h63);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      check_eq("reset h", 32'(n_h), 32'h00);
      check_eq("reset v", 32'(n_v), 32'h0FA);
      check_eq("reset pal v", 32'(p_v), 32'h0C8);

      for (int f = 0; f < 80; f++) begin
         repeat (1 + $urandom_range(0, 3)) cyc(1'b1, 1'b0);
         repeat (1 + $urandom_range(0, 3)) cyc(1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
